sort_sched: RTL and testbench

Frame scheduler for the bitonic-sort pipeline. It sits between `uart_rx` and `tx_buffer` and packs received bytes into one DEPTH×WIDTH frame. It then issues a single start to the sorter core and waits for its done pulse. Finally it hands the sorted array to `tx_buffer`, honouring `full`, and keeps counts of aborted frames and overrun bytes.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/byte_packer.sv | 63 ++++++
 rtl/sort_sched.sv | 108 ++++++++++
 tb/tb_sort_sched.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types, default frame geometry and helpers for the bitonic-sort frame path
// (used by sort_sched and tx_buffer).
package sort_pkg;

  localparam int SORT_WIDTH = 32;
  localparam int SORT_DEPTH = 8;

  typedef logic [SORT_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_PUSH    = 2'd3
  } state_t;

  // Saturating 8-bit event counter step
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs received bytes LS-first into a DEPTH x WIDTH frame, written in place.
// Raises frame_done on the last byte and abort when rx_end hits a partial frame.
module byte_packer
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int DEPTH = SORT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_end,
  output logic [WIDTH-1:0] frame [DEPTH-1:0],
  output logic             frame_done,
  output logic             abort
);

  localparam int BPW    = WIDTH / 8;
  localparam int NBYTES = DEPTH * BPW;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] cnt_r;
  logic          wr_s;
  logic          last_s;

  // rx_end outranks a simultaneous byte, so the byte never lands
  assign wr_s       = en & rx_valid & ~rx_end;
  assign last_s     = (cnt_r == CW'(NBYTES - 1));
  assign frame_done = wr_s & last_s;
  assign abort      = en & rx_end & (cnt_r != {CW{1'b0}});

  // Byte position counter: wraps on the last byte, clears on abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (abort) begin
      cnt_r <= {CW{1'b0}};
    end else if (wr_s) begin
      cnt_r <= last_s ? {CW{1'b0}} : cnt_r + CW'(1'b1);
    end
  end

  genvar w;
  generate
    for (w = 0; w < DEPTH; w++) begin : g_word
      // In-place lane write of the byte addressed by cnt_r within this word
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          frame[w] <= {WIDTH{1'b0}};
        end else if (wr_s) begin
          for (int b = 0; b < BPW; b++) begin
            if (cnt_r == CW'(w * BPW + b)) begin
              frame[w][b*8 +: 8] <= rx_data;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sort_sched.sv
// Frame scheduler: collects a frame, starts the sorter once, waits for done and
// hands the sorted frame to tx_buffer under full backpressure.
module sort_sched
  import sort_pkg::*;
#(
  parameter int WIDTH = SORT_WIDTH,
  parameter int DEPTH = SORT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_end,
  output logic             sort_start,
  output logic [WIDTH-1:0] sort_array [DEPTH-1:0],
  input  logic             sort_done,
  input  logic [WIDTH-1:0] sort_result [DEPTH-1:0],
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_array [DEPTH-1:0],
  input  logic             tx_full,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       ovr_cnt
);

  state_t state_r;
  logic   collect_s;
  logic   frame_done_s;
  logic   abort_s;

  assign collect_s = (state_r == S_COLLECT);

  byte_packer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (collect_s),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_end     (rx_end),
    .frame      (sort_array),
    .frame_done (frame_done_s),
    .abort      (abort_s)
  );

  // Decoded from the state register so reset removes it without waiting for a clock
  assign tx_valid = (state_r == S_PUSH) & ~tx_full;

  // Frame sequencing FSM with registered handshake outputs and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_COLLECT;
      sort_start <= 1'b0;
      busy       <= 1'b0;
      drop_cnt   <= 8'h00;
      ovr_cnt    <= 8'h00;
      tx_array   <= '{default: {WIDTH{1'b0}}};
    end else begin
      case (state_r)
        S_COLLECT: begin
          sort_start <= 1'b0;
          if (abort_s) begin
            drop_cnt <= sat_inc8(drop_cnt);
          end
          if (frame_done_s) begin
            state_r    <= S_START;
            sort_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          if (rx_valid) begin
            ovr_cnt <= sat_inc8(ovr_cnt);
          end
          sort_start <= 1'b0;
          state_r    <= S_WAIT;
        end
        S_WAIT: begin
          if (rx_valid) begin
            ovr_cnt <= sat_inc8(ovr_cnt);
          end
          if (sort_done) begin
            tx_array <= sort_result;
            state_r  <= S_PUSH;
          end
        end
        S_PUSH: begin
          // A byte in the transfer cycle is still overrun; collection resumes after it
          if (rx_valid) begin
            ovr_cnt <= sat_inc8(ovr_cnt);
          end
          if (!tx_full) begin
            state_r <= S_COLLECT;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r    <= S_COLLECT;
          sort_start <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched against a byte-queue reference model.
module tb_sort_sched;
  import sort_pkg::*;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 8;
  localparam int BPW    = WIDTH / 8;
  localparam int NBYTES = DEPTH * BPW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             rx_end = 1'b0;
  logic             sort_start;
  logic [WIDTH-1:0] sort_array [DEPTH-1:0];
  logic             sort_done = 1'b0;
  logic [WIDTH-1:0] sort_result [DEPTH-1:0];
  logic             tx_valid;
  logic [WIDTH-1:0] tx_array [DEPTH-1:0];
  logic             tx_full = 1'b0;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic [7:0]       ovr_cnt;

  int checks = 0;
  int errors = 0;
  int tx_pulses = 0;
  int start_pulses = 0;
  word_t cap_tx [DEPTH];

  // reference model: bytes of the frame in progress, last complete frame, counters
  logic [7:0] m_q [$];
  logic [7:0] m_frame [$];
  int         m_drop = 0;
  int         m_ovr = 0;
  bit         m_busy = 1'b0;
  word_t      m_res [DEPTH];

  sort_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_end(rx_end),
    .sort_start(sort_start), .sort_array(sort_array), .sort_done(sort_done),
    .sort_result(sort_result), .tx_valid(tx_valid), .tx_array(tx_array), .tx_full(tx_full),
    .busy(busy), .drop_cnt(drop_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_valid === 1'b1) begin
      tx_pulses++;
      for (int i = 0; i < DEPTH; i++) cap_tx[i] = tx_array[i];
    end
    if (sort_start === 1'b1) start_pulses++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  function automatic word_t exp_word(input int w);
    word_t r;
    for (int b = 0; b < BPW; b++) r[b*8 +: 8] = m_frame[w*BPW + b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 0;
    m_ovr = 0;
    m_busy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic endp);
    rx_data = b; rx_valid = 1'b1; rx_end = endp;
    if (m_busy) begin
      m_ovr = sat(m_ovr);
    end else if (endp) begin
      if (m_q.size() > 0) begin m_drop = sat(m_drop); m_q.delete(); end
    end else begin
      m_q.push_back(b);
      if (m_q.size() == NBYTES) begin m_frame = m_q; m_q.delete(); m_busy = 1'b1; end
    end
    tick();
    rx_valid = 1'b0; rx_end = 1'b0;
  endtask

  task automatic pulse_end();
    rx_end = 1'b1;
    if (!m_busy && m_q.size() > 0) begin m_drop = sat(m_drop); m_q.delete(); end
    tick();
    rx_end = 1'b0;
  endtask

  // sorter stand-in answer: the frame words in ascending order
  task automatic compute_res();
    word_t t;
    for (int w = 0; w < DEPTH; w++) m_res[w] = exp_word(w);
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH - 1 - i; j++)
        if (m_res[j] > m_res[j+1]) begin t = m_res[j]; m_res[j] = m_res[j+1]; m_res[j+1] = t; end
    for (int w = 0; w < DEPTH; w++) sort_result[w] = m_res[w];
  endtask

  // drive the sorter/tx side from the S_START cycle through the transfer
  task automatic finish_sort(input int delay, input int stall);
    tick();
    repeat (delay) tick();
    compute_res();
    sort_done = 1'b1; tx_full = (stall != 0);
    tick();
    sort_done = 1'b0;
    repeat (stall) tick();
    tx_full = 1'b0;
    tick();
    m_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, sort_start, tx_valid, drop_cnt, ovr_cnt} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b start=%b txv=%b drop=%0d ovr=%0d, want all 0",
               busy, sort_start, tx_valid, drop_cnt, ovr_cnt);
    end
    for (int w = 0; w < DEPTH; w++) begin
      checks++;
      if (sort_array[w] !== 32'h0 || tx_array[w] !== 32'h0) begin
        errors++;
        $display("FAIL reset_arrays[%0d]: got sort=%h tx=%h, want 0", w, sort_array[w], tx_array[w]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame_fill();
    int s0 = start_pulses;
    for (int i = 0; i < NBYTES; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (sort_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_start: got start=%b busy=%b, want 1 1", sort_start, busy);
    end
    checks++;
    if (sort_array[0] !== 32'h03020100 || sort_array[7] !== 32'h1F1E1D1C) begin
      errors++;
      $display("FAIL fill_words: got w0=%h w7=%h, want 03020100 1f1e1d1c", sort_array[0], sort_array[7]);
    end
    for (int w = 0; w < DEPTH; w++) begin
      checks++;
      if (sort_array[w] !== exp_word(w)) begin
        errors++;
        $display("FAIL fill_word[%0d]: got %h want %h", w, sort_array[w], exp_word(w));
      end
    end
    tick();
    checks++;
    if (sort_start !== 1'b0 || start_pulses != s0 + 1) begin
      errors++;
      $display("FAIL fill_one_start: got start=%b pulses=%0d, want 0 and %0d", sort_start, start_pulses - s0, 1);
    end
  endtask

  task automatic test_sort_handoff();
    int p0;
    repeat (4) tick();
    for (int i = 0; i < DEPTH; i++) sort_result[i] = 32'(7 - i);
    sort_done = 1'b1;
    p0 = tx_pulses;
    tick();
    sort_done = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL handoff_valid: got txv=%b busy=%b, want 1 1", tx_valid, busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (tx_array[i] !== 32'(7 - i)) begin
        errors++;
        $display("FAIL handoff_array[%0d]: got %h want %h", i, tx_array[i], 32'(7 - i));
      end
    end
    tick();
    m_busy = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_pulses != p0 + 1) begin
      errors++;
      $display("FAIL handoff_after: got txv=%b busy=%b pulses=%0d, want 0 0 1", tx_valid, busy, tx_pulses - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0, bad;
    for (int i = 0; i < NBYTES; i++) send_byte(8'($urandom), 1'b0);
    tick();
    compute_res();
    tx_full = 1'b1; sort_done = 1'b1;
    p0 = tx_pulses;
    tick();
    sort_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b1) bad++;
      for (int w = 0; w < DEPTH; w++) if (tx_array[w] !== m_res[w]) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || tx_pulses != p0) begin
      errors++;
      $display("FAIL bp_stall: got %0d bad cycles, %0d pulses, want 0 0", bad, tx_pulses - p0);
    end
    tx_full = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got txv=%b want 1", tx_valid);
    end
    tick();
    m_busy = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_pulses != p0 + 1) begin
      errors++;
      $display("FAIL bp_single: got txv=%b busy=%b pulses=%0d, want 0 0 1", tx_valid, busy, tx_pulses - p0);
    end
    for (int w = 0; w < DEPTH; w++) begin
      checks++;
      if (cap_tx[w] !== m_res[w]) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %h want %h", w, cap_tx[w], m_res[w]);
      end
    end
  endtask

  task automatic test_abort();
    int s0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
    pulse_end();
    checks++;
    if (drop_cnt !== 8'(m_drop) || drop_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got drop=%0d busy=%b, want %0d 0", drop_cnt, busy, m_drop);
    end
    for (int i = 0; i < NBYTES; i++) send_byte(8'(8'h80 + i), 1'b0);
    for (int w = 0; w < DEPTH; w++) begin
      checks++;
      if (sort_array[w] !== exp_word(w) || sort_start !== 1'b1) begin
        errors++;
        $display("FAIL abort_clean[%0d]: got %h start=%b want %h 1", w, sort_array[w], sort_start, exp_word(w));
      end
    end
    finish_sort(2, 0);
    s0 = start_pulses;
    for (int i = 0; i < NBYTES - 1; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'hEE, 1'b1);
    checks++;
    if (drop_cnt !== 8'(m_drop) || ovr_cnt !== 8'(m_ovr) || ovr_cnt !== 8'd0 ||
        busy !== 1'b0 || sort_start !== 1'b0 || start_pulses != s0) begin
      errors++;
      $display("FAIL abort_last: got drop=%0d ovr=%0d busy=%b start=%b, want %0d 0 0 0",
               drop_cnt, ovr_cnt, busy, sort_start, m_drop);
    end
  endtask

  task automatic test_overrun();
    int p0;
    for (int i = 0; i < NBYTES; i++) send_byte(8'($urandom), 1'b0);
    tick();
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    checks++;
    if (ovr_cnt !== 8'(m_ovr) || ovr_cnt !== 8'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_count: got ovr=%0d busy=%b want 3 1", ovr_cnt, busy);
    end
    for (int w = 0; w < DEPTH; w++) begin
      checks++;
      if (sort_array[w] !== exp_word(w)) begin
        errors++;
        $display("FAIL ovr_frame[%0d]: got %h want %h", w, sort_array[w], exp_word(w));
      end
    end
    compute_res();
    sort_done = 1'b1;
    p0 = tx_pulses;
    tick();
    sort_done = 1'b0;
    send_byte(8'h5A, 1'b0);
    m_busy = 1'b0;
    checks++;
    if (ovr_cnt !== 8'(m_ovr) || tx_pulses != p0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_transfer: got ovr=%0d pulses=%0d busy=%b want %0d 1 0", ovr_cnt, tx_pulses - p0, busy, m_ovr);
    end
    for (int i = 0; i < NBYTES; i++) send_byte(8'(8'h40 + i), 1'b0);
    checks++;
    if (sort_array[0] !== 32'h43424140 || sort_array[0] !== exp_word(0)) begin
      errors++;
      $display("FAIL ovr_next_frame: got w0=%h want 43424140", sort_array[0]);
    end
    finish_sort(1, 0);
  endtask

  task automatic test_reset_mid_sort();
    int p0, bad;
    for (int i = 0; i < NBYTES; i++) send_byte(8'($urandom), 1'b0);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({busy, sort_start, tx_valid, drop_cnt, ovr_cnt} !== 19'h0 || sort_array[0] !== 32'h0 ||
        tx_array[0] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got busy=%b start=%b txv=%b drop=%0d ovr=%0d w0=%h, want 0",
               busy, sort_start, tx_valid, drop_cnt, ovr_cnt, sort_array[0]);
    end
    tick();
    rst_n = 1'b1;
    sort_done = 1'b1;
    p0 = tx_pulses;
    tick();
    sort_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || tx_pulses != p0) begin
      errors++;
      $display("FAIL rst_late_done: got %0d bad cycles %0d pulses, want 0 0", bad, tx_pulses - p0);
    end
    for (int i = 0; i < NBYTES; i++) send_byte(8'($urandom), 1'b0);
    tick();
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_txv: got txv=%b busy=%b want 0 0", tx_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int n, d, stall, p0;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) pulse_end();
      if ($urandom_range(0, 1) == 1) begin
        n = int'($urandom_range(1, NBYTES - 1));
        for (int k = 0; k < n; k++) send_byte(8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
        else pulse_end();
      end
      for (int k = 0; k < NBYTES; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(8'($urandom), 1'b0);
      end
      checks++;
      if (sort_start !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_start[%0d]: got start=%b busy=%b want 1 1", f, sort_start, busy);
      end
      for (int w = 0; w < DEPTH; w++) begin
        checks++;
        if (sort_array[w] !== exp_word(w)) begin
          errors++;
          $display("FAIL rnd_frame[%0d][%0d]: got %h want %h", f, w, sort_array[w], exp_word(w));
        end
      end
      tick();
      compute_res();
      d = int'($urandom_range(1, 6));
      for (int j = 0; j < d; j++) begin
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'($urandom_range(0, 1)));
        else tick();
      end
      stall = int'($urandom_range(0, 4));
      p0 = tx_pulses;
      sort_done = 1'b1; tx_full = (stall != 0);
      tick();
      sort_done = 1'b0;
      repeat (stall) tick();
      checks++;
      if (tx_pulses != p0) begin
        errors++;
        $display("FAIL rnd_stall[%0d]: got %0d pulses during stall want 0", f, tx_pulses - p0);
      end
      tx_full = 1'b0;
      tick();
      m_busy = 1'b0;
      checks++;
      if (tx_pulses != p0 + 1 || busy !== 1'b0 || drop_cnt !== 8'(m_drop) || ovr_cnt !== 8'(m_ovr)) begin
        errors++;
        $display("FAIL rnd_done[%0d]: got pulses=%0d busy=%b drop=%0d ovr=%0d want 1 0 %0d %0d",
                 f, tx_pulses - p0, busy, drop_cnt, ovr_cnt, m_drop, m_ovr);
      end
      for (int w = 0; w < DEPTH; w++) begin
        checks++;
        if (cap_tx[w] !== m_res[w]) begin
          errors++;
          $display("FAIL rnd_tx[%0d][%0d]: got %h want %h", f, w, cap_tx[w], m_res[w]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sort_result[i] = 32'h0;
    test_reset();
    test_frame_fill();
    test_sort_handoff();
    test_backpressure();
    test_abort();
    test_overrun();
    test_reset_mid_sort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
